fxp6s_qavg: RTL and testbench

Windowed quotient averager sitting directly downstream of the fxp6s sign-magnitude divider. Accepts one 6-bit sign-magnitude quotient per handshake, together with the divider's divide-by-zero flag. Accumulates 2^LOG2_WIN valid quotients, emits their mean in the same fxp6s format (LSB = 2^-2), and reports how many divide-by-zero samples were discarded during the window.

---
 rtl/fxp6s_pkg.sv | 22 ++
 rtl/fxp6s_sm2tc.sv | 25 ++
 rtl/fxp6s_qavg.sv | 124 ++++++++++++
 tb/tb_fxp6s_qavg.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fxp6s_pkg.sv
// rtl/fxp6s_pkg.sv - shared fxp6s format constants and the averager state encoding
//
// Purpose: common definitions for the fxp6s sign-magnitude blocks.
//   FXP6S_WIDTH   total quotient width (sign + magnitude)
//   FXP6S_MAG_W   magnitude width
//   FXP6S_LSB_POW exponent of the magnitude LSB (LSB = 0.25)
//   DBZ_CNT_MAX   saturation value of the divide-by-zero counter
//   state_t       averager FSM states
package fxp6s_pkg;

  localparam int FXP6S_WIDTH   = 6;
  localparam int FXP6S_MAG_W   = 5;
  localparam int FXP6S_LSB_POW = -2;

  localparam logic [3:0] DBZ_CNT_MAX = 4'd15;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/fxp6s_sm2tc.sv
// rtl/fxp6s_sm2tc.sv - fxp6s sign-magnitude to two's-complement converter
//
// Purpose: combinational conversion of a 6-bit sign-magnitude value to 6-bit
// two's complement in -31..+31. Negative zero (100000) maps to 0.
// Ports:
//   sm  in  6  sign-magnitude value, bit 5 = sign, bits 4:0 = magnitude
//   tc  out 6  two's-complement value
module fxp6s_sm2tc
  import fxp6s_pkg::*;
(
  input  logic [FXP6S_WIDTH-1:0]        sm,
  output logic signed [FXP6S_WIDTH-1:0] tc
);

  logic [FXP6S_WIDTH-1:0] mag_ext;

  assign mag_ext = {1'b0, sm[FXP6S_MAG_W-1:0]};

  // A zero magnitude negates to zero, so negative zero needs no special case.
  always_comb begin
    if (sm[FXP6S_WIDTH-1]) tc = $signed(-mag_ext);
    else                   tc = $signed(mag_ext);
  end

endmodule

// File: rtl/fxp6s_qavg.sv
// rtl/fxp6s_qavg.sv - windowed mean of fxp6s divider quotients with dbz count
//
// Purpose: averages 2^LOG2_WIN valid quotients and reports the number of
// divide-by-zero samples discarded in the window.
// Build option: define FXP6S_QAVG_ROUND_EN to round the mean magnitude half
// away from zero; otherwise the magnitude is truncated toward zero.
// Ports:
//   clk          in   1  clock
//   rstn         in   1  synchronous active-low reset
//   in_valid     in   1  quotient valid
//   in_ready     out  1  quotient accepted this cycle when valid
//   in_q         in   6  sign-magnitude quotient
//   in_dbz       in   1  divide-by-zero flag, in_q ignored when set
//   out_valid    out  1  window result valid
//   out_ready    in   1  downstream accepts result
//   out_avg      out  6  window mean, sign-magnitude
//   out_dbz_cnt  out  4  dbz samples seen in the window, saturating
module fxp6s_qavg
  import fxp6s_pkg::*;
#(
  parameter int LOG2_WIN = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FXP6S_WIDTH-1:0] in_q,
  input  logic                   in_dbz,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP6S_WIDTH-1:0] out_avg,
  output logic [3:0]             out_dbz_cnt
);

  localparam int ACC_W = FXP6S_WIDTH + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;
  localparam int WIN   = 1 << LOG2_WIN;

  state_t state, state_nxt;

  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       sum;
  logic [CNT_W-1:0]              cnt;
  logic [3:0]                    dbz_cnt;
  logic signed [FXP6S_WIDTH-1:0] q_tc;
  logic [ACC_W-1:0]              m;
  logic [ACC_W-1:0]              m_r;
  logic [FXP6S_MAG_W-1:0]        mag;
  logic [FXP6S_WIDTH-1:0]        avg_nxt;
  logic                          accept;
  logic                          take;
  logic                          last;

  fxp6s_sm2tc u_sm2tc (
    .sm (in_q),
    .tc (q_tc)
  );

  assign accept = in_valid && in_ready;
  assign take   = accept && !in_dbz;
  assign last   = take && (cnt == CNT_W'(WIN - 1));

  // The result is formed from acc + current sample so the window closes on
  // the accepting edge rather than one cycle later.
  assign sum = acc + $signed({{LOG2_WIN{q_tc[FXP6S_WIDTH-1]}}, q_tc});

  always_comb begin
    m = sum[ACC_W-1] ? ACC_W'(-sum) : ACC_W'(sum);
`ifdef FXP6S_QAVG_ROUND_EN
    m_r = m + ACC_W'(1 << (LOG2_WIN - 1));
`else
    m_r = m;
`endif
    mag     = m_r[LOG2_WIN +: FXP6S_MAG_W];
    // A zero mean is reported as +0 regardless of the sum's sign.
    avg_nxt = {sum[ACC_W-1] && (mag != '0), mag};
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= ACCUM;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = rstn && (state == ACCUM);
    out_valid = (state == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc         <= '0;
      cnt         <= '0;
      dbz_cnt     <= '0;
      out_avg     <= '0;
      out_dbz_cnt <= '0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc     <= '0;
        cnt     <= '0;
        dbz_cnt <= '0;
      end
    end else if (accept) begin
      if (in_dbz) begin
        if (dbz_cnt != DBZ_CNT_MAX) dbz_cnt <= dbz_cnt + 4'd1;
      end else if (last) begin
        out_avg     <= avg_nxt;
        out_dbz_cnt <= dbz_cnt;
      end else begin
        acc <= sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fxp6s_qavg.sv
// tb/tb_fxp6s_qavg.sv - directed self-checking bench for fxp6s_qavg
module tb_fxp6s_qavg;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_q = 6'd0;
  logic       in_dbz = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out_avg;
  logic [3:0] out_dbz_cnt;

  int tests = 0;
  int fails = 0;

  fxp6s_qavg #(.LOG2_WIN(2)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_q        (in_q),
    .in_dbz      (in_dbz),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_avg     (out_avg),
    .out_dbz_cnt (out_dbz_cnt)
  );

  always #5 clk = ~clk;

  // Stimulus only: present one sample and return on the negedge after it is taken.
  task automatic send(input logic [5:0] q, input logic d);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1; in_q = q; in_dbz = d;
    @(negedge clk);
    in_valid = 1'b0; in_dbz = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (out_valid !== 1'b0)  begin fails++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    tests++; if (out_avg !== 6'd0)    begin fails++; $display("FAIL reset_out_avg: got %b exp 000000", out_avg); end
    tests++; if (out_dbz_cnt !== 4'd0) begin fails++; $display("FAIL reset_dbz_cnt: got %0d exp 0", out_dbz_cnt); end
    tests++; if (in_ready !== 1'b0)   begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    rstn = 1'b1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1)   begin fails++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    send(6'b000100, 1'b0);
    send(6'b001000, 1'b0);
    send(6'b001100, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b exp 0", out_valid); end
    send(6'b010000, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b exp 1", out_valid); end
    tests++; if (out_avg !== 6'b001010) begin fails++; $display("FAIL basic_avg: got %b exp 001010", out_avg); end
    tests++; if (out_dbz_cnt !== 4'd0) begin fails++; $display("FAIL basic_dbz: got %0d exp 0", out_dbz_cnt); end
    pop();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_clear: got %b exp 0", out_valid); end
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL basic_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_rounding();
    logic [5:0] exp_avg;
`ifdef FXP6S_QAVG_ROUND_EN
    exp_avg = 6'b000001;
`else
    exp_avg = 6'b000000;
`endif
    send(6'b000001, 1'b0);
    send(6'b000001, 1'b0);
    send(6'b000001, 1'b0);
    send(6'b000000, 1'b0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL round_valid: got %b exp 1", out_valid); end
    tests++; if (out_avg !== exp_avg) begin fails++; $display("FAIL round_avg: got %b exp %b", out_avg, exp_avg); end
    pop();
  endtask

  task automatic test_sign_zero();
    send(6'b011111, 1'b0);
    send(6'b111111, 1'b0);
    send(6'b100000, 1'b0);
    send(6'b000000, 1'b0);
    tests++; if (out_avg !== 6'b000000) begin fails++; $display("FAIL zero_avg: got %b exp 000000", out_avg); end
    pop();
    for (int i = 0; i < 4; i++) send(6'b100100, 1'b0);
    tests++; if (out_avg !== 6'b100100) begin fails++; $display("FAIL neg_avg: got %b exp 100100", out_avg); end
    pop();
  endtask

  task automatic test_dbz();
    send(6'b001000, 1'b0);
    send(6'b111111, 1'b1);
    send(6'b001000, 1'b0);
    send(6'b011111, 1'b1);
    send(6'b001000, 1'b0);
    send(6'b000001, 1'b1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dbz_early_close: got %b exp 0", out_valid); end
    send(6'b001000, 1'b0);
    tests++; if (out_valid !== 1'b1)   begin fails++; $display("FAIL dbz_close: got %b exp 1", out_valid); end
    tests++; if (out_avg !== 6'b001000) begin fails++; $display("FAIL dbz_avg: got %b exp 001000", out_avg); end
    tests++; if (out_dbz_cnt !== 4'd3)  begin fails++; $display("FAIL dbz_cnt3: got %0d exp 3", out_dbz_cnt); end
    pop();
    for (int i = 0; i < 20; i++) send(6'b010101, 1'b1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dbz_only_valid: got %b exp 0", out_valid); end
    for (int i = 0; i < 4; i++) send(6'b000000, 1'b0);
    tests++; if (out_dbz_cnt !== 4'd15) begin fails++; $display("FAIL dbz_sat: got %0d exp 15", out_dbz_cnt); end
    tests++; if (out_avg !== 6'b000000) begin fails++; $display("FAIL dbz_sat_avg: got %b exp 000000", out_avg); end
    pop();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) send(6'b000100, 1'b0);
    in_valid = 1'b1; in_q = 6'b011111;
    for (int i = 0; i < 5; i++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b exp 1", i, out_valid); end
      tests++; if (out_avg !== 6'b000100) begin fails++; $display("FAIL bp_avg[%0d]: got %b exp 000100", i, out_avg); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b exp 0", i, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop();
    tests++; if (in_ready !== 1'b1)  begin fails++; $display("FAIL bp_in_ready_after: got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_after: got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid_window();
    send(6'b011111, 1'b0);
    send(6'b011111, 1'b1);
    send(6'b011111, 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 1'b0)    begin fails++; $display("FAIL mid_rst_in_ready: got %b exp 0", in_ready); end
    tests++; if (out_valid !== 1'b0)   begin fails++; $display("FAIL mid_rst_valid: got %b exp 0", out_valid); end
    tests++; if (out_avg !== 6'd0)     begin fails++; $display("FAIL mid_rst_avg: got %b exp 000000", out_avg); end
    tests++; if (out_dbz_cnt !== 4'd0) begin fails++; $display("FAIL mid_rst_dbz: got %0d exp 0", out_dbz_cnt); end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) send(6'b000100, 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_stale_close: got %b exp 0", out_valid); end
    send(6'b000100, 1'b0);
    tests++; if (out_avg !== 6'b000100) begin fails++; $display("FAIL mid_rst_avg_after: got %b exp 000100", out_avg); end
    tests++; if (out_dbz_cnt !== 4'd0)  begin fails++; $display("FAIL mid_rst_dbz_after: got %0d exp 0", out_dbz_cnt); end
    pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_sign_zero();
    test_dbz();
    test_backpressure();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
